// File: rtl/smart_watch_pkg.sv
// Shared definitions for the smart-watch UART path: arbiter state encoding
// and byte/port constants used by the arbiter and its interface.
package smart_watch_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int ARB_NUM_REQ = 3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Sender-side and uart_tx-side signals of the UART transmit arbiter.
// The arbiter uses the slave modport; the surrounding logic uses master.
interface uart_tx_arbiter_if
    import smart_watch_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ
);
    logic [NUM_REQ-1:0]             req_i;
    logic [NUM_REQ-1:0]             send_start_i;
    logic [UART_BYTE_W*NUM_REQ-1:0] ascii_data_i;
    logic                           tx_busy;
    logic [NUM_REQ-1:0]             busy_o;
    logic [NUM_REQ-1:0]             grant_o;
    logic                           send_start;
    logic [UART_BYTE_W-1:0]         ascii_data;
    logic                           timeout_o;

    modport slave (
        input  req_i, send_start_i, ascii_data_i, tx_busy,
        output busy_o, grant_o, send_start, ascii_data, timeout_o
    );

    modport master (
        output req_i, send_start_i, ascii_data_i, tx_busy,
        input  busy_o, grant_o, send_start, ascii_data, timeout_o
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request strictly after ptr,
// wrapping around, so the last-served index gets lowest priority.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ) and keep the first hit.
    always_comb begin
        int k;
        k      = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[k]) begin
                any       = 1'b1;
                onehot[k] = 1'b1;
                idx       = IDX_W'(k);
            end else begin
                onehot[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ ASCII senders, one whole message per grant,
// round-robin between messages. Optional watchdog release under ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import smart_watch_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);

    arb_state_e             state_r, state_s;
    logic [NUM_REQ-1:0]     grant_r, grant_s;
    logic [IDX_W-1:0]       cur_idx_r, cur_idx_s;
    logic [IDX_W-1:0]       rr_ptr_r, rr_ptr_s;
    logic                   drain_cnt_r, drain_cnt_s;
    logic                   timeout_r, timeout_s;

    logic [NUM_REQ-1:0]     pick_onehot_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic                   pick_any_s;
    logic                   active_s;
    logic                   quiet_s;
    logic                   send_start_s;
    logic [UART_BYTE_W-1:0] ascii_data_s;
    logic [NUM_REQ-1:0]     busy_s;

`ifdef ARB_TIMEOUT_EN
    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WDOG_W-1:0]      wdog_r, wdog_s;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (bus.req_i),
        .ptr     (rr_ptr_r),
        .onehot  (pick_onehot_s),
        .idx     (pick_idx_s),
        .any     (pick_any_s)
    );

    // Zero-latency mux of the granted sender onto uart_tx and gated busy back.
    always_comb begin
        active_s     = (state_r == ARB_GRANT) || (state_r == ARB_DRAIN);
        send_start_s = 1'b0;
        ascii_data_s = '0;
        busy_s       = '1;
        if (active_s) begin
            send_start_s = bus.send_start_i[cur_idx_r];
            ascii_data_s = bus.ascii_data_i[int'(cur_idx_r)*UART_BYTE_W +: UART_BYTE_W];
        end else begin
            send_start_s = 1'b0;
            ascii_data_s = '0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (active_s && grant_r[k]) begin
                busy_s[k] = bus.tx_busy;
            end else begin
                busy_s[k] = 1'b1;
            end
        end
    end

    assign bus.send_start = send_start_s;
    assign bus.ascii_data = ascii_data_s;
    assign bus.busy_o     = busy_s;
    assign bus.grant_o    = grant_r;
    assign bus.timeout_o  = timeout_r;

    // Next-state logic; DRAIN waits two quiet cycles to cover the busy rise lag.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        cur_idx_s   = cur_idx_r;
        rr_ptr_s    = rr_ptr_r;
        drain_cnt_s = drain_cnt_r;
        timeout_s   = 1'b0;
        quiet_s     = !bus.tx_busy && !send_start_s;
        case (state_r)
            ARB_IDLE: begin
                drain_cnt_s = 1'b0;
                if (pick_any_s) begin
                    grant_s   = pick_onehot_s;
                    cur_idx_s = pick_idx_s;
                    state_s   = ARB_GRANT;
                end else begin
                    state_s   = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                drain_cnt_s = 1'b0;
                if (!bus.req_i[cur_idx_r]) begin
                    state_s = ARB_DRAIN;
                end else begin
                    state_s = ARB_GRANT;
                end
            end
            ARB_DRAIN: begin
                if (quiet_s && drain_cnt_r) begin
                    drain_cnt_s = 1'b0;
                    grant_s     = '0;
                    rr_ptr_s    = cur_idx_r;
                    state_s     = ARB_IDLE;
                end else if (quiet_s) begin
                    drain_cnt_s = 1'b1;
                end else begin
                    drain_cnt_s = 1'b0;
                end
            end
            default: begin
                state_s     = ARB_IDLE;
                grant_s     = '0;
                drain_cnt_s = 1'b0;
            end
        endcase

`ifdef ARB_TIMEOUT_EN
        // Watchdog overrides the FSM when a granted sender stops strobing.
        wdog_s = wdog_r;
        if (!active_s || send_start_s) begin
            wdog_s = '0;
        end else if (wdog_r == WDOG_W'(TIMEOUT - 1)) begin
            wdog_s      = '0;
            timeout_s   = 1'b1;
            grant_s     = '0;
            rr_ptr_s    = cur_idx_r;
            drain_cnt_s = 1'b0;
            state_s     = ARB_IDLE;
        end else begin
            wdog_s = wdog_r + WDOG_W'(1);
        end
`endif
    end

    // State register; rr_ptr resets to the top index so sender 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ARB_IDLE;
            grant_r     <= '0;
            cur_idx_r   <= '0;
            rr_ptr_r    <= IDX_W'(NUM_REQ - 1);
            drain_cnt_r <= 1'b0;
            timeout_r   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wdog_r      <= '0;
`endif
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            cur_idx_r   <= cur_idx_s;
            rr_ptr_r    <= rr_ptr_s;
            drain_cnt_r <= drain_cnt_s;
            timeout_r   <= timeout_s;
`ifdef ARB_TIMEOUT_EN
            wdog_r      <= wdog_s;
`endif
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ ASCII message senders: distance, temperature/humidity and watch-time reports.
- Grants the transmitter to one sender at a time for a whole message, using round-robin between messages.
- Muxes the granted sender's send_start and ascii_data onto the UART, and returns a gated tx_busy to each sender.
- Sits between the ascii_sender_* blocks and uart_tx in the top level.

Parameters:
- NUM_REQ, 3, number of sender ports (2..8).
- IDX_W, 2, grant index width (ceil log2 NUM_REQ; at least 1).
- TIMEOUT, 1_000_000, cycles without a send_start before the watchdog forces a release. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- req_i  in  NUM_REQ  per-sender message request. Level signal, held high for the whole message.
- send_start_i  in  NUM_REQ  per-sender byte strobe (1 cycle).
- ascii_data_i  in  8*NUM_REQ  packed byte bus; sender k occupies bits [8k+7:8k].
- tx_busy  in  1  busy flag from uart_tx.
- busy_o  out  NUM_REQ  gated busy returned to each sender.
- grant_o  out  NUM_REQ  one-hot grant; all zero when idle.
- send_start  out  1  byte strobe to uart_tx.
- ascii_data  out  8  byte to uart_tx.
- timeout_o  out  1  1-cycle pulse on a watchdog release. Driven 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset values: state=IDLE, grant_o=0, rr_ptr=NUM_REQ-1 (so req 0 wins first), wdog=0, timeout_o=0.
- Reset-driven outputs: send_start=0, ascii_data=0, busy_o=all ones.
- States: IDLE, GRANT, DRAIN (2-bit encoding).
- IDLE:
  - If any req_i is high, choose the first requester searching upward from rr_ptr+1 with wrap-around.
  - Register it into grant_o and cur_idx and go to GRANT. Grant appears 1 cycle after req.
  - With no req, stay in IDLE.
- GRANT:
  - send_start = send_start_i[cur_idx]; ascii_data = ascii_data_i[cur_idx]. Combinational, zero latency.
  - When req_i[cur_idx] falls, go to DRAIN.
- DRAIN:
  - Outputs stay muxed from cur_idx, so a strobe coincident with the req fall still passes.
  - Return to IDLE once tx_busy=0 and send_start=0 for 2 consecutive cycles. This covers uart_tx's 1-cycle busy rise lag.
  - On leaving DRAIN: rr_ptr <= cur_idx, grant_o <= 0.
- Outputs outside GRANT/DRAIN: send_start=0, ascii_data=0.
- busy_o[k]:
  - = tx_busy when k is granted and the state is GRANT or DRAIN.
  - = 1 otherwise, so ungranted senders never start.
- Strobes from ungranted senders are dropped; no buffering.
- Simultaneous requests: round-robin order. After serving k, k has lowest priority.
- A requester re-asserting req in the DRAIN exit cycle competes normally at the next IDLE.
- Minimum 1 IDLE cycle between grants.
- If req_i[cur_idx] drops before any byte is sent, DRAIN still completes and the grant is released.
- Reset mid-message: immediate return to reset values. A uart_tx frame already in flight is not aborted by this block.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - wdog counts cycles in GRANT/DRAIN and clears on every forwarded send_start.
  - At wdog==TIMEOUT-1: pulse timeout_o, force grant_o=0, rr_ptr <= cur_idx, go to IDLE.
  - The stuck sender sees busy_o=1 until it drops req and is granted again.
- ARB_TIMEOUT_EN not defined: no counter; grant held indefinitely; timeout_o tied 0.

Decomposition:
- Shared package smart_watch_pkg: state encodings ARB_IDLE/ARB_GRANT/ARB_DRAIN, and constants UART_BYTE_W=8 and ARB_NUM_REQ=3.
- One sub-module: rr_pick. Combinational round-robin selector taking req vector and pointer, returning one-hot and index.

Test Plan:
- Single request: req_i=001, sender 0 sends 20 bytes "DISTANCE = 012.3 cm\n" with a uart_tx model busy 10 cycles per byte.
  -> grant_o=001 one cycle after req. All 20 bytes reach ascii_data in order. grant_o=000 two idle-busy cycles after req falls.
- Simultaneous requests: req_i=111 from reset.
  -> grants in order 001, 010, 100, each holding for its full message.
  -> busy_o for waiting senders stays 1 throughout.
- Fairness: sender 0 re-requests immediately after every message while sender 2 holds req.
  -> alternating grants 001, 100, 001. Sender 0 never wins twice in a row while sender 2 waits.
- Ungranted strobe: sender 1 pulses send_start_i with 0x41 while sender 0 holds the grant.
  -> send_start stays 0 for that strobe; ascii_data never shows 0x41.
- Reset mid-message: pull rst=0 at byte 7.
  -> grant_o=0, busy_o=111, send_start=0 on the same edge. After release, req_i=010 is granted first-wins from rr_ptr=2.
- ARB_TIMEOUT_EN with TIMEOUT=100: granted sender holds req but never strobes.
  -> timeout_o pulses at cycle 100 after grant, grant_o=0, next pending requester granted.
